// File: rtl/marine_radar_tx_buffer_pkg.sv
// Shared constants and read-side state encoding
// for the host-to-radar TX packet buffer.
package marine_radar_tx_buffer_pkg;

  localparam int MR_DW        = 16;
  localparam int MR_PKT_WORDS = 256;
  localparam int MR_AW        = 8;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/marine_radar_tx_buffer_dpram.sv
// Two-bank packet RAM: one write port and one
// registered read port with read enable.
module mr_tx_dpram #(
  parameter int DW    = 16,
  parameter int ABITS = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [2**ABITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/marine_radar_tx_buffer.sv
// Host-to-radar ping-pong packet buffer: FX2 words in,
// whole 256-word packets out over valid/ready.
module marine_radar_tx_buffer
  import marine_radar_tx_buffer_pkg::*;
#(
  parameter int DW        = MR_DW,
  parameter int PKT_WORDS = MR_PKT_WORDS,
  parameter int AW        = MR_AW
) (
  input  logic          usbclk,
  input  logic          reset_n,
  input  logic [DW-1:0] usbdata,
  input  logic          WR,
  output logic          have_space,
  input  logic          clear_status,
  output logic          tx_overrun,
  output logic          tx_short_pkt,
  output logic          tx_underrun,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_sop,
  output logic          dout_eop
);

  logic          wr_prev;
  logic          wr_drop;
  logic [AW:0]   wr_count;
  logic          wr_bank;
  logic [1:0]    full;
  rd_state_t     state;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   fa;
  logic          q_valid;
  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic [DW-1:0] ram_q;
  logic          armed;

  logic          wr_rise;
  logic          wr_fall;
  logic          drop_now;
  logic          wr_block;
  logic          we;
  logic          fill;
  logic          short_evt;
  logic [1:0]    fill_vec;
  logic [1:0]    free_vec;
  logic [1:0]    full_n;
  logic          accept;
  logic          last_beat;
  logic          hold_all;
  logic          re;
  logic          under_set;

  assign wr_rise   = WR & ~wr_prev;
  assign wr_fall   = ~WR & wr_prev;
  assign drop_now  = wr_rise & full[wr_bank];
  assign wr_block  = wr_drop | drop_now;
  assign we        = WR & ~wr_block & ~wr_count[AW];
  assign fill      = wr_fall & ~wr_drop & wr_count[AW];
  assign short_evt = wr_fall & ~wr_drop & ~wr_count[AW]
                   & (wr_count != '0);
  assign fill_vec  = fill ? (2'b01 << wr_bank) : 2'b00;

  assign dout_valid = skid_valid | q_valid;
  assign accept     = dout_valid & dout_ready;
  assign last_beat  = accept
                    & (rd_addr == AW'(PKT_WORDS - 1));
  assign free_vec   = last_beat ? (2'b01 << rd_bank) : 2'b00;
  assign full_n     = (full | fill_vec) & ~free_vec;

  // Skid and RAM output both occupied and stalled: freeze the RAM
  assign hold_all = skid_valid & q_valid & ~accept;
  assign re = (state == RD_FETCH)
            | ((state == RD_STREAM) & ~fa[AW] & ~hold_all);

  assign dout = ~dout_valid ? '0
              : skid_valid  ? skid_data
              : ram_q;
  assign dout_sop  = dout_valid & (rd_addr == '0);
  assign dout_eop  = dout_valid
                   & (rd_addr == AW'(PKT_WORDS - 1));
  assign under_set = armed & dout_ready & ~dout_valid;

  mr_tx_dpram #(
    .DW    (DW),
    .ABITS (AW + 1)
  ) u_ram (
    .clk   (usbclk),
    .we    (we),
    .waddr ({wr_bank, wr_count[AW-1:0]}),
    .wdata (usbdata),
    .re    (re),
    .raddr ({rd_bank, fa[AW-1:0]}),
    .rdata (ram_q)
  );

  always_ff @(posedge usbclk) begin
    if (!reset_n) begin
      wr_prev      <= 1'b0;
      wr_drop      <= 1'b0;
      wr_count     <= '0;
      wr_bank      <= 1'b0;
      full         <= 2'b00;
      have_space   <= 1'b1;
      state        <= RD_IDLE;
      rd_bank      <= 1'b0;
      rd_addr      <= '0;
      fa           <= '0;
      q_valid      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      armed        <= 1'b0;
      tx_overrun   <= 1'b0;
      tx_short_pkt <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      wr_prev <= WR;
      wr_drop <= WR & wr_block;
      if (!WR) wr_count <= '0;
      else if (we) wr_count <= wr_count + 1'b1;
      if (fill) wr_bank <= ~wr_bank;
      full       <= full_n;
      have_space <= ~&full_n;

      if (accept) rd_addr <= rd_addr + 1'b1;
      if (re) fa <= fa + 1'b1;
      if (!hold_all) begin
        q_valid    <= re;
        skid_valid <= (skid_valid & ~accept)
                    | (q_valid & (skid_valid | ~accept));
        if (q_valid && (skid_valid || !accept))
          skid_data <= ram_q;
      end

      unique case (state)
        RD_IDLE:
          if (full[rd_bank]) state <= RD_FETCH;
        RD_FETCH:
          state <= RD_STREAM;
        RD_STREAM:
          if (last_beat) begin
            rd_bank <= ~rd_bank;
            fa      <= '0;
            state   <= full[~rd_bank] ? RD_FETCH
                                      : RD_IDLE;
          end
        default:
          state <= RD_IDLE;
      endcase

      armed        <= armed | last_beat;
      tx_overrun   <= drop_now
                    | (tx_overrun & ~clear_status);
      tx_short_pkt <= short_evt
                    | (tx_short_pkt & ~clear_status);
      tx_underrun  <= under_set
                    | (tx_underrun & ~clear_status);
    end
  end

endmodule

// File: tb/tb_marine_radar_tx_buffer.sv
// Directed-vector bench for the TX packet buffer:
// table-driven packet runs plus hand-written corner cases.
module tb_marine_radar_tx_buffer;

  logic        usbclk = 1'b0;
  logic        reset_n;
  logic [15:0] usbdata;
  logic        WR;
  logic        have_space;
  logic        clear_status;
  logic        tx_overrun;
  logic        tx_short_pkt;
  logic        tx_underrun;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_sop;
  logic        dout_eop;

  int nvec = 0;
  int nerr = 0;

  always #5 usbclk = ~usbclk;

  marine_radar_tx_buffer dut (
    .usbclk       (usbclk),
    .reset_n      (reset_n),
    .usbdata      (usbdata),
    .WR           (WR),
    .have_space   (have_space),
    .clear_status (clear_status),
    .tx_overrun   (tx_overrun),
    .tx_short_pkt (tx_short_pkt),
    .tx_underrun  (tx_underrun),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_sop     (dout_sop),
    .dout_eop     (dout_eop)
  );

  typedef struct {
    logic        wr;
    logic [15:0] data;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic        ee;
    logic        esp;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge usbclk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  // One packet of nwr WR-high cycles, consumer always ready.
  // First beat appears two edges after the WR-fall edge.
  task automatic build_tbl(input int nwr,
                           input logic [15:0] base);
    vec_t v;
    tbl.delete();
    for (int k = 0; k <= nwr + 258; k++) begin
      v.wr   = (k < nwr);
      v.data = base + 16'(k);
      v.rdy  = 1'b1;
      v.ev   = (k >= nwr + 2) && (k <= nwr + 257);
      v.ed   = base + 16'(k - nwr - 2);
      v.es   = (k == nwr + 2);
      v.ee   = (k == nwr + 257);
      v.esp  = 1'b1;
      tbl.push_back(v);
    end
  endtask

  task automatic run_tbl(input string tag);
    foreach (tbl[k]) begin
      WR         = tbl[k].wr;
      usbdata    = tbl[k].data;
      dout_ready = tbl[k].rdy;
      step();
      chk($sformatf("%s[%0d] valid", tag, k),
          dout_valid, tbl[k].ev);
      if (tbl[k].ev) begin
        chk($sformatf("%s[%0d] dout", tag, k),
            dout, tbl[k].ed);
        chk($sformatf("%s[%0d] sop", tag, k),
            dout_sop, tbl[k].es);
        chk($sformatf("%s[%0d] eop", tag, k),
            dout_eop, tbl[k].ee);
      end
      chk($sformatf("%s[%0d] space", tag, k),
          have_space, tbl[k].esp);
    end
  endtask

  task automatic send_pkt(input int n,
                          input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      WR      = 1'b1;
      usbdata = base + 16'(i);
      step();
    end
    WR = 1'b0;
    step();
  endtask

  task automatic drain(input logic [15:0] base,
                       input string tag);
    int t;
    int e0;
    t  = 0;
    e0 = nerr;
    dout_ready = 1'b1;
    while (!dout_valid && t < 16) begin
      step();
      t++;
    end
    for (int i = 0; i < 256 && nerr == e0; i++) begin
      chk({tag, " valid"}, dout_valid, 1);
      chk({tag, " data"}, dout, base + 16'(i));
      chk({tag, " sop"}, dout_sop, i == 0);
      chk({tag, " eop"}, dout_eop, i == 255);
      step();
    end
  endtask

  int          bi;
  int          cyc;
  int          t6;
  logic        pv;
  logic        pr;
  logic [15:0] pd;

  initial begin
    reset_n      = 1'b0;
    WR           = 1'b0;
    usbdata      = '0;
    clear_status = 1'b0;
    dout_ready   = 1'b0;
    step();
    step();
    chk("rst space", have_space, 1);
    chk("rst valid", dout_valid, 0);
    chk("rst sop", dout_sop, 0);
    chk("rst eop", dout_eop, 0);
    chk("rst dout", dout, 0);
    chk("rst ovr", tx_overrun, 0);
    chk("rst short", tx_short_pkt, 0);
    chk("rst under", tx_underrun, 0);
    reset_n = 1'b1;

    build_tbl(256, 16'h0000);
    run_tbl("t1");
    chk("t1 under pre", tx_underrun, 0);
    step();
    chk("t1 under set", tx_underrun, 1);
    clear_status = 1'b1;
    step();
    chk("t1 set beats clr", tx_underrun, 1);
    dout_ready = 1'b0;
    step();
    clear_status = 1'b0;
    chk("t1 under clr", tx_underrun, 0);

    build_tbl(260, 16'h0000);
    run_tbl("t2");
    chk("t2 ovr", tx_overrun, 0);
    chk("t2 short", tx_short_pkt, 0);

    dout_ready   = 1'b0;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    send_pkt(256, 16'h1000);
    chk("t3 space p1", have_space, 1);
    send_pkt(256, 16'h2000);
    chk("t3 space p2", have_space, 0);
    chk("t3 ovr pre", tx_overrun, 0);
    send_pkt(256, 16'h3000);
    chk("t3 ovr", tx_overrun, 1);
    chk("t3 short", tx_short_pkt, 0);
    chk("t3 stall valid", dout_valid, 1);
    chk("t3 stall dout", dout, 16'h1000);
    chk("t3 stall sop", dout_sop, 1);
    drain(16'h1000, "t3a");
    drain(16'h2000, "t3b");
    dout_ready = 1'b0;
    repeat (6) step();
    chk("t3 p3 dropped", dout_valid, 0);
    chk("t3 space end", have_space, 1);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t3 ovr clr", tx_overrun, 0);

    send_pkt(100, 16'h4000);
    chk("t4 short", tx_short_pkt, 1);
    repeat (4) step();
    chk("t4 no valid", dout_valid, 0);
    chk("t4 space", have_space, 1);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("t4 short clr", tx_short_pkt, 0);
    send_pkt(256, 16'h5000);
    drain(16'h5000, "t4");

    dout_ready = 1'b0;
    send_pkt(256, 16'h6000);
    bi  = 0;
    cyc = 0;
    while (bi < 256 && cyc < 4000) begin
      dout_ready = 1'($urandom_range(0, 1));
      if (dout_valid) begin
        chk("t5 dout", dout, 16'h6000 + 16'(bi));
        chk("t5 sop", dout_sop, bi == 0);
        chk("t5 eop", dout_eop, bi == 255);
      end
      pv = dout_valid;
      pr = dout_ready;
      pd = dout;
      step();
      cyc++;
      if (pv && pr) bi++;
      else if (pv) begin
        chk("t5 hold valid", dout_valid, 1);
        chk("t5 hold dout", dout, pd);
      end
    end
    chk("t5 beats", bi, 256);

    dout_ready = 1'b1;
    send_pkt(256, 16'h7000);
    t6 = 0;
    while (!dout_valid && t6 < 16) begin
      step();
      t6++;
    end
    repeat (40) step();
    chk("t6 word40", dout, 16'h7028);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t6 rst valid", dout_valid, 0);
    chk("t6 rst space", have_space, 1);
    chk("t6 rst dout", dout, 0);
    chk("t6 rst under", tx_underrun, 0);
    send_pkt(256, 16'h8000);
    drain(16'h8000, "t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
